uart_alu_if: RTL and testbench
==============================

// Module: uart_alu_if
// PURPOSE
//  Frame-level consumer of the UART receiver: collects 3 received bytes (operand A, operand B, opcode).
//  Presents them to the combinational ALU and captures the result.
//  Hands the result byte to the UART transmitter and waits for completion before accepting the next frame.
//  Sits between uart_rx (upstream), the ALU (side) and uart_tx (downstream).
// PARAMETERS
//  DATA_W          8        operand/result/byte width (equals UART data bits)
//  OP_W            6        ALU opcode width; low OP_W bits of the opcode byte are used
//  TIMEOUT_CYCLES  500000   inter-byte timeout in clk cycles (only with UART_ALU_TIMEOUT_EN)
// PORTS
//  clk         in   1       system clock
//  reset       in   1       asynchronous, active-high
//  rx_data     in   DATA_W  byte from receiver, valid when rx_valid=1
//  rx_valid    in   1       one-cycle strobe per received byte
//  alu_a       out  DATA_W  operand A to ALU (registered)
//  alu_b       out  DATA_W  operand B to ALU (registered)
//  alu_op      out  OP_W    opcode to ALU (registered)
//  alu_result  in   DATA_W  combinational ALU result
//  tx_data     out  DATA_W  byte for transmitter (registered, held until tx_done)
//  tx_start    out  1       one-cycle start strobe to transmitter
//  tx_busy     in   1       transmitter busy
//  tx_done     in   1       one-cycle strobe at end of stop bit
//  rx_overrun  out  1       one-cycle pulse when rx_valid is dropped (EXEC/SEND/WAIT_TX)
//  frame_err   out  1       one-cycle pulse on inter-byte timeout (0 when timeout compiled out)
// BEHAVIOUR
//  Reset: state=GET_A; alu_a=alu_b=0; alu_op=0; tx_data=0; tx_start=0; rx_overrun=0; frame_err=0.
//  Reset is honoured in any state; a half-collected frame is discarded and no tx_start is issued.
//  FSM states: GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
//  GET_A --rx_valid--> GET_B: alu_a<=rx_data.
//  GET_B --rx_valid--> GET_OP: alu_b<=rx_data.
//  GET_OP --rx_valid--> EXEC: alu_op<=rx_data[OP_W-1:0]; upper opcode bits are ignored.
//  EXEC lasts exactly 1 cycle: tx_data<=alu_result, ->SEND. ALU inputs are stable for that full cycle.
//  SEND: if tx_busy=0, then tx_start<=1 (high only during the first WAIT_TX cycle), ->WAIT_TX; else stay.
//  WAIT_TX: on tx_done ->GET_A. tx_done seen while tx_start is high is also accepted.
//  Latency: opcode rx_valid at cycle n; EXEC at n+1; tx_start high at n+3 (tx_busy low).
//  rx_valid in EXEC/SEND/WAIT_TX: byte discarded, rx_overrun=1 the next cycle, state unchanged.
//  Operand registers are held until overwritten by the next frame; no arithmetic is done in this block.
//  tx_start is never asserted twice per frame; tx_data is stable from EXEC exit until tx_done.
// CONFIGURATION
//  UART_ALU_TIMEOUT_EN defined:
//   - A counter clears on each accepted byte and runs only in GET_B/GET_OP.
//   - When it reaches TIMEOUT_CYCLES-1: ->GET_A, frame_err pulses 1 cycle, partial operands are kept but unused.
//   - rx_valid in the same cycle as expiry wins: the byte is accepted and there is no error.
//  Not defined: no counter is built; frame_err is tied 0; the FSM waits indefinitely for each byte.
// STRUCTURE
//  Package uart_alu_pkg:
//   - state enum uart_alu_state_t (3-bit).
//   - opcode localparams OP_ADD=6'h20, OP_SUB=6'h22, OP_AND=6'h24, OP_OR=6'h25, OP_XOR=6'h26, OP_SRA=6'h03, OP_SRL=6'h02, OP_NOR=6'h27.
//  Sub-module: uart_frame_timer, the timeout counter with clear/enable/expired ports.
//   - Instantiated only under UART_ALU_TIMEOUT_EN.
// TESTING
//  1 rx bytes 0x05,0x03,0x20; ALU model=ADD -> alu_a=0x05, alu_b=0x03, alu_op=0x20; tx_data=0x08; one tx_start 3 cycles after opcode strobe.
//  2 tx_busy=1 for 40 cycles after EXEC -> stays in SEND; tx_start is issued the cycle after tx_busy falls; tx_data remains 0x08.
//  3 extra rx_valid (0xAA) during WAIT_TX -> rx_overrun 1-cycle pulse; next frame 0x0F,0x01,0x22 gives tx_data=0x0E.
//  4 reset asserted after bytes A,B only -> all outputs 0, state GET_A; next full frame processed normally, no stray tx_start.
//  5 UART_ALU_TIMEOUT_EN, TIMEOUT_CYCLES=100: send 0x11, then idle 100 cycles -> frame_err pulse; 0x02,0x03,0x24 then gives tx_data=0x02.
//  6 back-to-back: 4 frames with tx_done returned 10 cycles after tx_start -> exactly 4 tx_start pulses with correct results.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART-to-ALU frame interface.
// Holds the FSM state encoding and the ALU opcode values carried in the opcode byte.
// No logic of its own; imported by the frame interface and its helpers.
package uart_alu_pkg;

  // Frame FSM: three collection states, one execute cycle, then the transmit handshake.
  typedef enum logic [2:0] {
    ST_GET_A   = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } uart_alu_state_t;

  // Opcodes understood by the side ALU (low 6 bits of the opcode byte).
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

  // True while the FSM is busy with a frame and cannot take another byte.
  function automatic logic st_drops_rx(input uart_alu_state_t st);
    return (st == ST_EXEC) || (st == ST_SEND) || (st == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: counts enabled idle cycles, flags expiry at TIMEOUT_CYCLES-1.
// Latency: expired is combinational from the count register (same cycle as the terminal count).
// No backpressure; clear or a deasserted enable returns the count to zero on the next edge.
module uart_frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear or when idle outside the window, saturate at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_alu_if.sv
// Collects A, B, opcode bytes from uart_rx, drives the ALU, sends the result byte to uart_tx.
// Latency: opcode strobe at cycle n -> EXEC at n+1 -> tx_start at n+3 when tx_busy is low.
// Backpressure: waits in SEND while tx_busy; bytes arriving outside collection are dropped and flagged via rx_overrun.
// Optional inter-byte timeout with frame_err: define UART_ALU_TIMEOUT_EN.
module uart_alu_if
  import uart_alu_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned OP_W           = 6,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              rx_overrun,
  output logic              frame_err
);

  if ((TIMEOUT_CYCLES < 1) || (OP_W > DATA_W)) begin : g_bad_params
    $error("uart_alu_if: TIMEOUT_CYCLES must be >= 1 and OP_W <= DATA_W");
  end

  uart_alu_state_t   state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              frame_err_q, frame_err_d;

  // Timeout fires only when no byte arrives in the expiry cycle: an arriving byte wins.
  logic timeout_hit;

`ifdef UART_ALU_TIMEOUT_EN
  logic tmr_clear;
  logic tmr_enable;
  logic tmr_expired;

  assign tmr_enable = (state_q == ST_GET_B) || (state_q == ST_GET_OP);
  assign tmr_clear  = rx_valid && !st_drops_rx(state_q);

  uart_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  assign timeout_hit = tmr_expired && !rx_valid;
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and register updates; strobes default low so each is a single-cycle pulse.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    rx_overrun_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      ST_GET_A: begin
        if (rx_valid) begin
          alu_a_d = rx_data;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (rx_valid) begin
          alu_b_d = rx_data;
          state_d = ST_GET_OP;
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          state_d     = ST_GET_A;
        end
      end
      ST_GET_OP: begin
        if (rx_valid) begin
          alu_op_d = rx_data[OP_W-1:0];
          state_d  = ST_EXEC;
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          state_d     = ST_GET_A;
        end
      end
      ST_EXEC: begin
        // ALU inputs have been stable since the opcode edge; capture its result.
        rx_overrun_d = rx_valid;
        tx_data_d    = alu_result;
        state_d      = ST_SEND;
      end
      ST_SEND: begin
        rx_overrun_d = rx_valid;
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        // tx_done coincident with tx_start (first WAIT_TX cycle) is accepted too.
        rx_overrun_d = rx_valid;
        if (tx_done) begin
          state_d = ST_GET_A;
        end
      end
      default: begin
        state_d = ST_GET_A;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_GET_A;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign rx_overrun = rx_overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_alu_if.sv
// Bench for uart_alu_if: drives byte frames, models the ALU and transmitter, scores results.
// Expected results come from the ALU function applied to the bytes sent.
// Timeout scenarios are exercised when UART_ALU_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_uart_alu_if;
  import uart_alu_pkg::*;

  localparam int T_CYC = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] alu_a, alu_b, alu_result, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, tx_busy, tx_done, rx_overrun, frame_err;
  logic       busy_force, busy_resp;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  int tx_lat = 10;
  int tx_cnt;
  int overrun_cnt = 0;
  int ferr_cnt = 0;
  int unstable_cnt = 0;
  logic [7:0] start_data;
  logic [7:0] start_q[$];
  logic [5:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return sa >>> b[2:0];
      OP_SRL:  return a >> b[2:0];
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);
  assign tx_busy    = busy_force | busy_resp;

  uart_alu_if #(.DATA_W(8), .OP_W(6), .TIMEOUT_CYCLES(T_CYC)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_overrun(rx_overrun), .frame_err(frame_err)
  );

  // Transmitter model: records each start, stays busy tx_lat cycles, then pulses tx_done.
  initial begin
    busy_resp = 1'b0; tx_done = 1'b0; tx_cnt = 0; start_data = 8'h00;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (reset === 1'b1) begin
        busy_resp = 1'b0;
      end else if (tx_start === 1'b1) begin
        starts++;
        start_q.push_back(tx_data);
        start_data = tx_data;
        if (tx_lat == 0) tx_done = 1'b1;
        else begin busy_resp = 1'b1; tx_cnt = tx_lat; end
      end else if (busy_resp) begin
        if (tx_data !== start_data) unstable_cnt++;
        tx_cnt--;
        if (tx_cnt == 0) begin tx_done = 1'b1; busy_resp = 1'b0; end
      end
    end
  end

  // Pulse counters for the error strobes.
  always @(negedge clk) begin
    if (rx_overrun === 1'b1) overrun_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input logic [7:0] exp, input int s0);
    logic [7:0] got;
    for (int i = 0; i < 300 && starts < s0 + 1; i++) @(negedge clk);
    for (int i = 0; i < 300 && busy_resp; i++) @(negedge clk);
    @(negedge clk);
    check({tag, "_starts"}, starts, s0 + 1);
    got = 'x;
    if (start_q.size() > 0) got = start_q.pop_front();
    check({tag, "_data"}, got, exp);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
    int s0;
    s0 = starts;
    send_byte(a);
    send_byte(b);
    send_byte(opb);
    finish_frame(tag, alu_fn(a, b, opb[5:0]), s0);
  endtask

  initial begin
    int s0, e0, waited, hold_bad, r;
    logic [7:0] a, b, opb;

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; busy_force = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic ADD frame with exact start latency.
    s0 = starts;
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
    check("t1_alu_a", alu_a, 8'h05);
    check("t1_alu_b", alu_b, 8'h03);
    check("t1_alu_op", alu_op, 6'h20);
    check("t1_start_n1", tx_start, 0);
    @(negedge clk);
    check("t1_start_n2", tx_start, 0);
    check("t1_tx_data", tx_data, 8'h08);
    @(negedge clk);
    check("t1_start_n3", tx_start, 1);
    finish_frame("t1", 8'h08, s0);

    // 2: transmitter busy holds the FSM in SEND.
    s0 = starts;
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
    busy_force = 1'b1;
    hold_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_start !== 1'b0) hold_bad++;
    end
    check("t2_no_start_busy", hold_bad, 0);
    check("t2_tx_data_held", tx_data, 8'h08);
    busy_force = 1'b0;
    @(negedge clk);
    check("t2_start_after_busy", tx_start, 1);
    finish_frame("t2", 8'h08, s0);

    // 3: byte during WAIT_TX is dropped and flagged.
    s0 = starts;
    send_byte(8'h07); send_byte(8'h09); send_byte(8'h26);
    for (int i = 0; i < 50 && starts < s0 + 1; i++) @(negedge clk);
    send_byte(8'hAA);
    check("t3_overrun_pulse", rx_overrun, 1);
    @(negedge clk);
    check("t3_overrun_clear", rx_overrun, 0);
    check("t3_alu_a_kept", alu_a, 8'h07);
    finish_frame("t3a", 8'h0E, s0);
    s0 = starts;
    send_byte(8'h0F); send_byte(8'h01); send_byte(8'h22);
    finish_frame("t3b", 8'h0E, s0);

    // 4: reset mid-frame discards the partial frame.
    s0 = starts;
    send_byte(8'h33); send_byte(8'h44);
    reset = 1'b1;
    @(negedge clk);
    check("t4_alu_a", alu_a, 0);
    check("t4_alu_b", alu_b, 0);
    check("t4_alu_op", alu_op, 0);
    check("t4_tx_data", tx_data, 0);
    check("t4_tx_start", tx_start, 0);
    check("t4_overrun", rx_overrun, 0);
    check("t4_frame_err", frame_err, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_no_stray_start", starts, s0);
    run_frame("t4", 8'h21, 8'h12, 8'h20);

    // 5: inter-byte timeout.
    e0 = ferr_cnt;
`ifdef UART_ALU_TIMEOUT_EN
    send_byte(8'h11);
    waited = 0;
    for (int i = 1; i <= T_CYC + 20 && frame_err !== 1'b1; i++) begin
      @(negedge clk);
      waited = i;
    end
    check("t5_timeout_cycle", waited, T_CYC);
    @(negedge clk);
    check("t5_ferr_one_cycle", frame_err, 0);
    s0 = starts;
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h24);
    check("t5_alu_a", alu_a, 8'h02);
    finish_frame("t5", 8'h02, s0);
    s0 = starts;
    send_byte(8'h44);
    repeat (T_CYC - 1) @(negedge clk);
    send_byte(8'h55);
    send_byte(8'h20);
    finish_frame("t5_edge", 8'h99, s0);
    check("t5_ferr_count", ferr_cnt, e0 + 1);
`else
    waited = 0;
    send_byte(8'h11);
    repeat (T_CYC + 50) @(negedge clk);
    check("t5_no_ferr", ferr_cnt, e0);
    s0 = starts;
    send_byte(8'h02); send_byte(8'h24);
    finish_frame("t5", 8'h00, s0);
`endif

    // 6: back-to-back random frames, fixed then random transmit latency.
    for (int f = 0; f < 12; f++) begin
      tx_lat = (f < 4) ? 10 : int'($urandom_range(0, 15));
      a = 8'($urandom);
      b = 8'($urandom);
      r = int'($urandom_range(0, 3));
      opb = {r[1:0], ops[$urandom_range(0, 7)]};
      run_frame("t6", a, b, opb);
    end

    check("overrun_total", overrun_cnt, 1);
    check("tx_data_stable", unstable_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
